// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: four-digit multiplexed 7-segment scanner with latched V/D fault display.
// Defining DISPLAY_SCAN_BLINK_EN makes the fault pattern blink; otherwise it is shown steadily.
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 16
) (
  input  logic        clk0,
  input  logic        rst_n,
  input  logic        v_sense,
  input  logic        d_valor,
  input  logic [2:0]  select,
  input  logic        clr_err,
  input  logic [15:0] digit_data,
  output logic [3:0]  digitos,
  output logic [6:0]  segmentos,
  output logic [1:0]  scan_idx,
  output logic        err_active
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  typedef enum logic [1:0] {NORMAL, ERR_SHOW, ERR_BLANK} state_t;
  state_t state, state_n;

  logic [CW-1:0] cnt;
  logic          started;
  logic          slot_tick;
  logic          frame_tick;
  logic          blink_done;
  logic [1:0]    next_idx;
  logic [1:0]    seg_idx;
  logic          v_err, d_err;
  logic          v_set, d_set;
  logic          v_err_n, d_err_n;
  logic [6:0]    seg_n;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign slot_tick  = (cnt == CW'(REFRESH_DIV - 1));
  assign frame_tick = slot_tick && started && (scan_idx == 2'd3);
  // The first tick after reset lights digit 0 rather than stepping past it.
  assign next_idx   = started ? scan_idx + 2'd1 : 2'd0;
  assign seg_idx    = slot_tick ? next_idx : scan_idx;

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      started  <= 1'b0;
      scan_idx <= 2'd0;
      digitos  <= 4'b1111;
    end else if (slot_tick) begin
      cnt      <= '0;
      started  <= 1'b1;
      scan_idx <= next_idx;
      digitos  <= ~(4'b0001 << next_idx);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Sticky faults; a set in the same cycle as clr_err wins.
  assign v_set   = v_sense && ((select == 3'b000) || (select == 3'b001));
  assign d_set   = d_valor && ((select == 3'b000) || (select == 3'b010));
  assign v_err_n = v_set || (v_err && !clr_err);
  assign d_err_n = d_set || (d_err && !clr_err);

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      v_err      <= 1'b0;
      d_err      <= 1'b0;
      err_active <= 1'b0;
    end else begin
      v_err      <= v_err_n;
      d_err      <= d_err_n;
      err_active <= v_err_n || d_err_n;
    end
  end

`ifdef DISPLAY_SCAN_BLINK_EN
  logic [7:0] frame_cnt;
  assign blink_done = frame_tick && (frame_cnt == 8'(BLINK_DIV - 1));

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) frame_cnt <= '0;
    else if (state_n != state) frame_cnt <= '0;
    else if (frame_tick && (state != NORMAL)) frame_cnt <= frame_cnt + 8'd1;
  end
`else
  logic [7:0] blink_unused;
  assign blink_done   = 1'b0;
  assign blink_unused = 8'(BLINK_DIV);
`endif

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) state <= NORMAL;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!err_active) begin
      state_n = NORMAL;
    end else begin
      case (state)
        NORMAL:    state_n = ERR_SHOW;
        ERR_SHOW:  if (blink_done) state_n = ERR_BLANK;
        ERR_BLANK: if (blink_done) state_n = ERR_SHOW;
        default:   state_n = NORMAL;
      endcase
    end
  end

  // Pattern for the digit that will be lit once this edge completes.
  always_comb begin
    seg_n = SEG_BLANK;
    case (state_n)
      NORMAL: seg_n = hex7(digit_data[{seg_idx, 2'b00} +: 4]);
      ERR_SHOW: begin
        if (seg_idx == 2'd0)      seg_n = SEG_E;
        else if (seg_idx == 2'd1) seg_n = (v_err && d_err) ? 7'b0100100 :
                                          (v_err ? 7'b1000000 : 7'b1111001);
      end
      default: seg_n = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) segmentos <= SEG_BLANK;
    else if (slot_tick || (state_n != state)) segmentos <= seg_n;
  end
endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, meaning clk0 cycles per digit slot (legal range 2..2^20).
REQ-002 Parameter BLINK_DIV, default 16, meaning scan frames per blink half-period (legal range 1..255).
REQ-003 Port clk0  input  1  single system clock; all state SHALL be on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port v_sense  input  1  V sensor fault, synchronous level.
REQ-006 Port d_valor  input  1  D value fault, synchronous level.
REQ-007 Port select  input  3  fault mask: 000 = both sources, 001 = V only, 010 = D only, other values = none.
REQ-008 Port clr_err  input  1  single-cycle pulse that clears latched faults.
REQ-009 Port digit_data  input  16  normal-mode hex values; nibble [4k+3:4k] drives digit k.
REQ-010 Port digitos  output  4  active-low digit enables.
REQ-011 Port segmentos  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-012 Port scan_idx  output  2  index of the currently enabled digit.
REQ-013 Port err_active  output  1  high while any fault is latched.

Function
REQ-014 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; the terminal count SHALL be one "slot tick".
REQ-015 scan_idx SHALL advance by 1 on each slot tick, wrapping 3->0; a tick with scan_idx=3 SHALL be a "frame tick".
REQ-016 digitos SHALL be the active-low one-hot of scan_idx (0->1110, 1->1101, 2->1011, 3->0111), registered, and SHALL change in the same cycle as scan_idx.
REQ-017 v_err SHALL set when v_sense=1 and select is 000 or 001; d_err SHALL set when d_valor=1 and select is 000 or 010; both SHALL be sticky.
REQ-018 clr_err SHALL clear v_err and d_err; if set and clear conditions coincide in one cycle, set SHALL win.
REQ-019 err_active SHALL equal v_err OR d_err, registered; it goes high 1 cycle after the qualifying input.
REQ-020 FSM states SHALL be NORMAL, ERR_SHOW and ERR_BLANK.
REQ-021 NORMAL->ERR_SHOW SHALL occur on the cycle after err_active rises; any state->NORMAL SHALL occur on the cycle after both faults clear.
REQ-022 ERR_SHOW<->ERR_BLANK SHALL toggle after BLINK_DIV frame ticks; the frame counter SHALL reset on entry to ERR_SHOW.
REQ-023 In NORMAL, segmentos SHALL be the hex decode (0-F) of the selected digit_data nibble, sampled at the slot tick.
REQ-024 In ERR_SHOW: digit0 = 'E' 0000110; digit1 = 0 (1000000) for V only, 1 (1111001) for D only, 2 (0100100) for both; digits 2 and 3 = blank 1111111.
REQ-025 In ERR_BLANK, segmentos SHALL be 1111111 while the digit scan continues.
REQ-026 segmentos SHALL update on slot ticks and on state transitions only, so it never glitches mid-slot.

Reset
REQ-027 While rst_n=0: counter=0, scan_idx=0, digitos=1111, segmentos=1111111, v_err=d_err=0, err_active=0, state=NORMAL.
REQ-028 Reset asserted mid-slot or mid-blink SHALL abort immediately; after release, the first slot tick SHALL come REFRESH_DIV cycles later and drive digitos=1110.

Configuration
REQ-029 Macro DISPLAY_SCAN_BLINK_EN: when defined, ERR_BLANK and the blink frame counter SHALL exist per REQ-022/025.
REQ-030 When DISPLAY_SCAN_BLINK_EN is undefined, ERR_SHOW SHALL be held steady, ERR_BLANK SHALL be unreachable, and BLINK_DIV SHALL be ignored.

Verification (REFRESH_DIV=4, BLINK_DIV=2)
REQ-031 Reset, then idle with digit_data=16'h3210 -> digitos sequence 1110,1101,1011,0111,1110 every 4 cycles; segmentos 1000000,1111001,0100100,0110000.
REQ-032 select=001, v_sense pulse of 1 cycle -> err_active=1 next cycle; digit0=0000110, digit1=1000000, digits 2-3=1111111.
REQ-033 select=000, v_sense=1 and d_valor=1 together -> digit1=0100100; select=011 with both faults high -> no latch, stays NORMAL.
REQ-034 Blink build: in a fault condition -> 2 frames ERR_SHOW, 2 frames all 1111111, repeating; non-blink build -> ERR_SHOW steady.
REQ-035 clr_err in the same cycle as d_valor=1 with select=010 -> d_err stays set; clr_err alone -> NORMAL one cycle after err_active falls.
REQ-036 rst_n low for 1 cycle during ERR_BLANK -> all outputs match REQ-027 immediately; first post-reset tick gives digitos=1110.
